// File: rtl/serial_left_shifter_pkg.sv
// Shared definitions for the iterative left shifter/rotator.
// - FSM state encodings (ST_IDLE / ST_SHIFT / ST_DONE, 2'b11 is unused)
// - Op encodings (OP_ROL / OP_SLL)
// - Default data and count widths
package serial_left_shifter_pkg;

  localparam int N_DEF = 16;
  localparam int C_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT   = 2'b01,
    ST_DONE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  localparam logic OP_ROL = 1'b0;
  localparam logic OP_SLL = 1'b1;

endpackage

// File: rtl/serial_left_shifter_step.sv
// One combinational left step: shift or rotate a word left by 1 or by 4.
// Ports:
//   In    - operand (N bits)
//   Op    - OP_SLL: zero fill, OP_ROL: refill from the MSBs
//   Step4 - 1: move by 4 bits, 0: move by 1 bit
//   Out   - stepped word (N bits)
// N must be at least 4.
module left_shift_step
  import serial_left_shifter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] In,
  input  logic         Op,
  input  logic         Step4,
  output logic [N-1:0] Out
);

  logic [3:0] fill4;
  logic       fill1;

  always_comb begin
    fill4 = (Op == OP_SLL) ? 4'b0000 : In[N-1 -: 4];
    fill1 = (Op == OP_SLL) ? 1'b0    : In[N-1];
    if (Step4) Out = {In[N-5:0], fill4};
    else       Out = {In[N-2:0], fill1};
  end

endmodule

// File: rtl/serial_left_shifter.sv
// Multi-cycle iterative left shifter/rotator (SLL / ROL).
// A request (In, Cnt, Op) is taken over a valid/ready handshake in IDLE,
// shifted 1 bit per cycle (or 4 bits while at least 4 remain when STEP4=1),
// and the result is held in the Out register until the consumer accepts it.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - request handshake (in_ready high only in IDLE)
//   In, Cnt, Op         - operand, shift amount, 1=SLL / 0=ROL
//   out_valid, out_ready- result handshake (out_valid high in DONE)
//   Out                 - registered result, updated only on DONE entry
//   busy                - high in SHIFT or DONE
module serial_left_shifter
  import serial_left_shifter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int C     = C_DEF,
  parameter int STEP4 = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic         Op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         busy
);

  state_t       state, state_nx;
  logic [N-1:0] data, data_sh;
  logic [C-1:0] rem, rem_nx, step_amt;
  logic         op;
  logic         step4;
  logic         accept;

  assign accept   = in_valid && in_ready;
  // Wide steps only while they cannot overshoot the remaining count.
  assign step4    = (STEP4 != 0) && (rem >= C'(4));
  assign step_amt = step4 ? C'(4) : C'(1);
  assign rem_nx   = rem - step_amt;

  left_shift_step #(.N(N)) u_step (
    .In    (data),
    .Op    (op),
    .Step4 (step4),
    .Out   (data_sh)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = (Cnt == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (rem_nx == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register, so nothing on the
  // output side depends combinationally on an input.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_SHIFT) || (state == ST_DONE);
  end

  // Datapath: working word, remaining count, latched op and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      rem  <= '0;
      op   <= 1'b0;
      Out  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data <= In;
            rem  <= Cnt;
            op   <= Op;
            if (Cnt == '0) Out <= In;
          end
        end
        ST_SHIFT: begin
          data <= data_sh;
          rem  <= rem_nx;
          if (rem_nx == '0) Out <= data_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_left_shifter.sv
// Scoreboard bench for serial_left_shifter: dut0 built with STEP4=0,
// dut1 with STEP4=1, sharing In/Cnt/Op/rst but with separate handshakes.
module tb_serial_left_shifter;
  import serial_left_shifter_pkg::*;

  localparam int N = 16;
  localparam int C = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       In;
  logic [C-1:0]       Cnt;
  logic               Op;
  logic [1:0]         in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0][N-1:0]  Out;

  always #5 clk = ~clk;

  serial_left_shifter #(.N(N), .C(C), .STEP4(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .In(In), .Cnt(Cnt), .Op(Op), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .Out(Out[0]), .busy(busy[0])
  );

  serial_left_shifter #(.N(N), .C(C), .STEP4(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .In(In), .Cnt(Cnt), .Op(Op), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .Out(Out[1]), .busy(busy[1])
  );

  typedef struct {
    logic [N-1:0] out;
    int           lat;
    int           acc;
  } exp_t;

  exp_t              q0[$], q1[$];
  bit   [1:0]        seen;
  logic [1:0][N-1:0] last_out;
  int                last_hs[2];
  int                cyc;
  int                n_cmp, n_err;

  // Reference: widen, shift by the full count, then either drop the
  // overflow (SLL) or fold it back into the low half (ROL).
  function automatic logic [N-1:0] model(logic [N-1:0] a, int cnt, logic op);
    logic [2*N-1:0] w;
    w = {{N{1'b0}}, a} << cnt;
    return (op == OP_SLL) ? w[N-1:0] : (w[N-1:0] | w[2*N-1:N]);
  endfunction

  // Edges from the accept edge (inclusive) until out_valid is seen high.
  function automatic int exp_lat(int d, int cnt);
    return (d == 1) ? (cnt / 4) + (cnt % 4) + 1 : cnt + 1;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, required %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pushes on observed request handshakes, pops and compares on
  // result handshakes, and measures latency at the first out_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete();
        q1.delete();
        seen = '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (out_valid[d]) begin
            if (qsize(d) == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL spurious_out_valid dut%0d: out_valid 1, required 0 (nothing pending)", d);
            end else begin
              e = (d == 0) ? q0[0] : q1[0];
              if (!seen[d]) begin
                seen[d] = 1'b1;
                check("latency", d, 32'(cyc - e.acc + 1), 32'(e.lat));
              end
              if (out_ready[d]) begin
                check("result", d, 32'(Out[d]), 32'(e.out));
                last_out[d] = Out[d];
                last_hs[d]  = cyc + 1;
                seen[d]     = 1'b0;
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
              end
            end
          end
          if (in_valid[d] && in_ready[d]) begin
            e.out = model(In, int'(Cnt), Op);
            e.lat = exp_lat(d, int'(Cnt));
            e.acc = cyc + 1;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
          end
        end
      end
    end
  end

  task automatic check_idle(input string name);
    for (int d = 0; d < 2; d++) begin
      check({name, "_out"},       d, 32'(Out[d]),       32'h0);
      check({name, "_out_valid"}, d, 32'(out_valid[d]), 32'h0);
      check({name, "_in_ready"},  d, 32'(in_ready[d]),  32'h1);
      check({name, "_busy"},      d, 32'(busy[d]),      32'h0);
    end
  endtask

  task automatic send(input int d, input logic [N-1:0] a, input int c, input logic o);
    int k = 0;
    while (!in_ready[d] && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) check("send_timeout", d, 32'(in_ready[d]), 32'h1);
    In = a; Cnt = C'(c); Op = o;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int k = 0;
    while (qsize(d) != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) check("drain_timeout", d, 32'(qsize(d)), 32'h0);
  endtask

  task automatic run1(input int d, input logic [N-1:0] a, input int c, input logic o,
                      input logic [N-1:0] want);
    send(d, a, c, o);
    drain(d);
    check("directed", d, 32'(last_out[d]), 32'(want));
  endtask

  task automatic b2b(input int d, input int n);
    int sum = 0, first = 0, k;
    In = N'($urandom); Cnt = C'($urandom_range(15, 0)); Op = 1'($urandom);
    in_valid[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!in_ready[d] && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 100) check("b2b_timeout", d, 32'(in_ready[d]), 32'h1);
      @(posedge clk); #1;
      if (i == 0) first = cyc;
      sum += exp_lat(d, int'(Cnt)) + 1;
      In = N'($urandom); Cnt = C'($urandom_range(15, 0)); Op = 1'($urandom);
    end
    in_valid[d] = 1'b0;
    drain(d);
    // Each request occupies exactly latency+1 edges when nothing stalls.
    check("b2b_throughput", d, 32'(last_hs[d] - first + 1), 32'(sum));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 2'b11;
    In = '0; Cnt = '0; Op = 1'b0;
    #12;
    check_idle("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_idle("post_reset");

    // Directed cases
    run1(0, 16'h8001, 1,  OP_ROL, 16'h0003);
    run1(0, 16'h8001, 1,  OP_SLL, 16'h0002);
    run1(0, 16'h0001, 15, OP_SLL, 16'h8000);
    run1(0, 16'h1234, 0,  OP_ROL, 16'h1234);
    run1(1, 16'h1234, 4,  OP_ROL, 16'h2341);
    run1(1, 16'h1234, 0,  OP_ROL, 16'h1234);
    run1(1, 16'h0001, 15, OP_SLL, 16'h8000);
    run1(1, 16'h8001, 1,  OP_ROL, 16'h0003);
    run1(1, 16'h00F0, 6,  OP_ROL, 16'h3C00);

    // Backpressure: result must hold, new requests ignored.
    out_ready[0] = 1'b0;
    send(0, 16'hA5C3, 3, OP_ROL);
    begin
      int k = 0;
      while (!out_valid[0] && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (k >= 100) check("bp_timeout", 0, 32'(out_valid[0]), 32'h1);
    end
    repeat (5) begin
      @(posedge clk); #1;
      in_valid[0] = 1'b1;
      In = N'($urandom);
      @(negedge clk);
      check("bp_out_valid", 0, 32'(out_valid[0]), 32'h1);
      check("bp_out",       0, 32'(Out[0]),       32'(model(16'hA5C3, 3, OP_ROL)));
      check("bp_in_ready",  0, 32'(in_ready[0]),  32'h0);
      check("bp_busy",      0, 32'(busy[0]),      32'h1);
    end
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    drain(0);
    check("bp_release", 0, 32'(last_out[0]), 32'h2E1D);

    // Reset in the middle of a long shift.
    send(0, 16'hBEEF, 10, OP_SLL);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_idle("mid_reset");
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    run1(0, 16'hBEEF, 10, OP_SLL, 16'hBC00);

    // Random back-to-back streams against the model.
    b2b(0, 1000);
    b2b(1, 400);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
